sram_sp_param: RTL

//  Parametrised single-port synchronous SRAM model; next generation of the fixed-size sram models.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_clr_fsm.sv | 64 ++++++
 rtl/sram_sp_param.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared types, latency bounds and parity helper for sram_sp_param.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

  typedef enum logic [0:0] {
    CLR = 1'b0,
    RUN = 1'b1
  } clr_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic f_even_par(input logic [31:0] i_d);
    return ^i_d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_clr_fsm.sv
`default_nettype none
// ============================================================================
// Module   : sram_clr_fsm
// Brief    : Post-reset clear engine; sweeps every word once, then raises RDY.
// Revision : 1.0 - initial release
// ============================================================================
module sram_clr_fsm
  import sram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          o_rdy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr
);

  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

  clr_state_t    r_state;
  clr_state_t    w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= CLR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_clr_we    = 1'b0;
    case (r_state)
      CLR: begin
        // No clear write on a reset cycle: contents survive until the sweep.
        o_clr_we = !RST;
        if (r_cnt == c_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = CLR;
      end
    endcase
  end

  assign o_clr_addr = r_cnt;
  assign o_rdy      = (r_state == RUN);

endmodule
`default_nettype wire

// File: rtl/sram_sp_param.sv
`default_nettype none
// ============================================================================
// Module   : sram_sp_param
// Brief    : Parametrised single-port SRAM model with bit mask, 1/2-cycle read
//            latency, post-reset clear and out-of-range flag.
//            Define SRAM_PARITY_EN to store and check an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module sram_sp_param
  import sram_pkg::*;
#(
  parameter int               A_WID    = 18,
  parameter int               D_WID    = 6,
  parameter int               DEPTH    = 146880,
  parameter int               RD_LAT   = 1,
  parameter logic [D_WID-1:0] INIT_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [A_WID-1:0] A,
  input  logic             CEN,
  input  logic             WEN,
  input  logic [D_WID-1:0] BWEN,
  input  logic [D_WID-1:0] D,
  output logic [D_WID-1:0] Q,
  output logic             QVLD,
  output logic             RDY,
  output logic             AERR,
  output logic             PERR
);

  localparam int             c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [A_WID:0] c_DEPTH = (A_WID + 1)'(DEPTH);
`ifdef SRAM_PARITY_EN
  localparam int             c_MW    = D_WID + 1;
`else
  localparam int             c_MW    = D_WID;
`endif

  generate
    if ((DEPTH < 1) || (longint'(DEPTH) > (64'd1 << A_WID))) begin : g_chk_depth
      $error("sram_sp_param: DEPTH must be in 1..2**A_WID");
    end
    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_chk_lat
      $error("sram_sp_param: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [c_MW-1:0]  r_mem [DEPTH];

  logic             w_rdy;
  logic             w_clr_we;
  logic [c_AW-1:0]  w_clr_addr;
  logic [c_AW-1:0]  w_idx;
  logic             w_inr;
  logic             w_acc;
  logic             w_uwr;
  logic             w_urd;
  logic [D_WID-1:0] w_old;
  logic [D_WID-1:0] w_new;
  logic [c_MW-1:0]  w_wr_word;
  logic [c_MW-1:0]  w_clr_word;
  logic             w_we;
  logic [c_AW-1:0]  w_waddr;
  logic [c_MW-1:0]  w_wdata;
  logic [c_MW-1:0]  w_rd_word;
  logic [c_MW-1:0]  r_q1;
  logic             r_v1;
  logic             r_aerr;
  logic [c_MW-1:0]  w_out_word;
  logic             w_out_v;

  sram_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_clr (
    .CLK        (CLK),
    .RST        (RST),
    .o_rdy      (w_rdy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // User port is live only once the clear sweep is done and reset is low.
  assign w_idx = A[c_AW-1:0];
  assign w_inr = ({1'b0, A} < c_DEPTH);
  assign w_acc = w_rdy && !RST && !CEN;
  assign w_uwr = w_acc && !WEN && w_inr;
  assign w_urd = w_acc && WEN;

  // Read-modify-write so masked bits keep their stored value.
  assign w_old = r_mem[w_idx][D_WID-1:0];
  assign w_new = (w_old & BWEN) | (D & ~BWEN);

`ifdef SRAM_PARITY_EN
  assign w_wr_word  = {f_even_par(32'(w_new)), w_new};
  assign w_clr_word = {f_even_par(32'(INIT_VAL)), INIT_VAL};
`else
  assign w_wr_word  = w_new;
  assign w_clr_word = INIT_VAL;
`endif

  assign w_we    = w_clr_we || w_uwr;
  assign w_waddr = w_clr_we ? w_clr_addr : w_idx;
  assign w_wdata = w_clr_we ? w_clr_word : w_wr_word;

  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Out-of-range reads return an all-zero word, which also has clean parity.
  assign w_rd_word = w_inr ? r_mem[w_idx] : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q1   <= '0;
      r_v1   <= 1'b0;
      r_aerr <= 1'b0;
    end else begin
      r_v1 <= w_urd;
      if (w_urd) begin
        r_q1 <= w_rd_word;
      end
      if (w_acc && !w_inr) begin
        r_aerr <= 1'b1;
      end
    end
  end

  generate
    if (RD_LAT == RD_LAT_MAX) begin : g_lat2
      logic [c_MW-1:0] r_q2;
      logic            r_v2;

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_q2 <= '0;
          r_v2 <= 1'b0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_q2 <= r_q1;
          end
        end
      end

      assign w_out_word = r_q2;
      assign w_out_v    = r_v2;
    end else begin : g_lat1
      assign w_out_word = r_q1;
      assign w_out_v    = r_v1;
    end
  endgenerate

  assign Q    = w_out_word[D_WID-1:0];
  assign QVLD = w_out_v;
  assign RDY  = w_rdy;
  assign AERR = r_aerr;

`ifdef SRAM_PARITY_EN
  assign PERR = w_out_v &&
                (f_even_par(32'(w_out_word[D_WID-1:0])) != w_out_word[D_WID]);
`else
  assign PERR = 1'b0;
`endif

endmodule
`default_nettype wire
